ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3, …) to the keyboard over the same two open-drain lines the PS/2 receive path listens on. It runs the host-request sequence, serialises data/parity/stop on device-generated clock edges and checks the device ACK bit. It sits beside `ps2_keyboard`. It holds `rx_hold` during a transfer so the receive path discards traffic it generates itself.

---
 rtl/ps2_defs_pkg.sv | 34 +++
 rtl/ps2_line_sync.sv | 29 ++
 rtl/ps2_host_tx.sv | 169 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_defs_pkg.sv
// Shared definitions for the PS/2 host transmitter and receive-side helpers.
package ps2_defs;

  // Host transmit sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_SEND    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } tx_state_e;

  // Debug view of the sequencer: state, device edge count and raw edge strobes.
  typedef struct packed {
    tx_state_e  state;
    logic [3:0] edges;
    logic       clk_fall;
    logic       data_fall;
  } tx_dbg_t;

  // Device clock edges in one host-to-device frame (8 data, parity, stop, ack).
  localparam int FRAME_BITS = 11;

  // 100 us inhibit and 15 ms frame limit at a 50 MHz system clock.
  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_FRAME_TIMEOUT  = 750000;

  // Odd parity bit: makes the total count of ones across data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 line with a falling-edge strobe.
// Flops reset to 1 so an idle (pulled-up) line never produces a spurious edge.
module ps2_line_sync (
  input  logic clk,
  input  logic clrn,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic meta;
  logic prev;

  // Synchronise the pin and keep one delayed copy for edge detection.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= pin;
      level <= meta;
      prev  <= level;
    end
  end

  assign fall = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues the request-to-send,
// shifts data/parity/stop on device clock falls and samples the device ACK.
//
// Handshake: a byte is taken on a rising clk edge where tx_valid && tx_ready.
// tx_ready is high only while idle; tx_valid outside that window is dropped,
// nothing is queued. Completion is reported by a one-cycle done (with ack_ok)
// or a one-cycle error, never both.
module ps2_host_tx
  import ps2_defs::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int FRAME_TIMEOUT  = DEF_FRAME_TIMEOUT
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_hold,
  output logic       done,
  output logic       ack_ok,
  output logic       error,
  output tx_dbg_t    dbg
);

  localparam int CNT_MAX = (FRAME_TIMEOUT > INHIBIT_CYCLES) ? FRAME_TIMEOUT : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(FRAME_TIMEOUT - 1);
  localparam logic [3:0]    ACK_EDGE  = 4'(FRAME_BITS);

  tx_state_e     state;
  logic [CW-1:0] cnt;
  logic [3:0]    edges;
  logic [7:0]    shreg;
  logic          parity;

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic data_fall;

  ps2_line_sync u_clk_sync (
    .clk   (clk),
    .clrn  (clrn),
    .pin   (ps2_clk_i),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk   (clk),
    .clrn  (clrn),
    .pin   (ps2_data_i),
    .level (data_level),
    .fall  (data_fall)
  );

  // Transmit sequencer; all bus drives and status flags are registered here.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= ST_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      rx_hold     <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      error       <= 1'b0;
      cnt         <= '0;
      edges       <= '0;
      shreg       <= '0;
      parity      <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            shreg       <= tx_data;
            parity      <= odd_parity(tx_data);
            cnt         <= '0;
            edges       <= '0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b0;
            rx_hold     <= 1'b1;
            state       <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt         <= '0;
            ps2_data_oe <= 1'b1;  // start bit
            state       <= ST_REQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_REQ: begin
          ps2_clk_oe <= 1'b0;     // hand the clock to the device
          cnt        <= '0;
          state      <= ST_SEND;
        end

        ST_SEND: begin
          if (clk_fall && edges == ACK_EDGE - 4'd1) begin
            ack_ok      <= ~data_level;
            ps2_data_oe <= 1'b0;
            edges       <= ACK_EDGE;
            state       <= ST_RELEASE;
          end else if (cnt == TO_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            error       <= 1'b1;
            rx_hold     <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (clk_fall) begin
              edges <= edges + 4'd1;
              if (edges < 4'd8) begin
                ps2_data_oe <= ~shreg[0];
                shreg       <= {1'b0, shreg[7:1]};
              end else if (edges == 4'd8) begin
                ps2_data_oe <= ~parity;
              end else begin
                ps2_data_oe <= 1'b0;  // stop bit: line released
              end
            end
          end
        end

        ST_RELEASE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (clk_level && data_level) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          rx_hold  <= 1'b0;
          tx_ready <= 1'b1;
          state    <= ST_IDLE;
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          rx_hold     <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign dbg = '{state: state, edges: edges, clk_fall: clk_fall, data_fall: data_fall};

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model drives the lines, and a monitor
// pops an expected-result queue on every done/error pulse.
module tb_ps2_host_tx;
  import ps2_defs::*;

  localparam int INH  = 20;
  localparam int FTO  = 2000;
  localparam int HALF = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, rx_hold, done, ack_ok, error;
  tx_dbg_t    dbg;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_i, ps2_data_i;

  // Open-drain lines with pull-ups.
  assign ps2_clk_i  = ~ps2_clk_oe  & dev_clk;
  assign ps2_data_i = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .FRAME_TIMEOUT(FTO)) dut (
    .clk(clk), .clrn(clrn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .rx_hold(rx_hold), .done(done), .ack_ok(ack_ok),
    .error(error), .dbg(dbg)
  );

  // ---------------- scoreboard ----------------
  // Entry: [11] end is error, [10] ack_ok expected, [9:0] data_oe at edges 10..1.
  logic [11:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  logic [9:0] obs_pattern = '0;

  int since_fall = 0;
  int hi_run = 0, inh_run = 0, last_hi = 0, last_inh = 0;
  logic prev_clk_oe = 1'b0;
  logic chk_ready_next = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: tracks clk_oe timing and checks every end-of-frame pulse.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (!clrn) begin
        prev_clk_oe    = 1'b0;
        hi_run         = 0;
        inh_run        = 0;
        chk_ready_next = 1'b0;
      end else begin
        if (chk_ready_next) begin
          check("tx_ready after end", 32'(tx_ready), 32'd1);
          chk_ready_next = 1'b0;
        end
        if (prev_clk_oe && !ps2_clk_oe) begin
          since_fall = 0;
          last_hi    = hi_run;
          last_inh   = inh_run;
          hi_run     = 0;
          inh_run    = 0;
        end else begin
          since_fall++;
        end
        if (ps2_clk_oe) begin
          hi_run++;
          if (!ps2_data_oe) inh_run++;
        end
        prev_clk_oe = ps2_clk_oe;

        if (done || error) begin
          if (exp_q.size() == 0) begin
            check("unexpected end pulse", {30'd0, done, error}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("end kind is error", 32'(error), 32'(e[11]));
            check("done/error exclusive", 32'(done & error), 32'd0);
            if (error) begin
              check("error delay", 32'(since_fall), 32'(FTO));
              check("oe after error", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
              check("ack_ok kept on error", 32'(ack_ok), 32'(e[10]));
            end else begin
              check("ack_ok", 32'(ack_ok), 32'(e[10]));
              check("data_oe pattern", 32'(obs_pattern), 32'(e[9:0]));
            end
            chk_ready_next = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] d);
    int k = 0;
    while (!tx_ready && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("tx_ready before send", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    check("clk_oe after accept", 32'(ps2_clk_oe), 32'd1);
    check("data_oe after accept", 32'(ps2_data_oe), 32'd0);
    check("tx_ready busy", 32'(tx_ready), 32'd0);
    check("rx_hold busy", 32'(rx_hold), 32'd1);
  endtask

  // Device: waits for the request, clocks last_edge falls, samples data_oe late
  // in each low phase and optionally pulls data low ahead of edge 11.
  task automatic device(input bit ack, input int last_edge);
    int k = 0;
    logic [9:0] obs = '0;
    obs_pattern = '0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && k < INH + 50) begin
      @(negedge clk);
      k++;
    end
    check("request seen", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd1);
    for (int n = 1; n <= last_edge; n++) begin
      repeat (HALF / 2) @(negedge clk);
      if (n == 11 && ack) dev_data = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (n <= 10) obs[n-1] = ps2_data_oe;
      if (n < last_edge || last_edge == 11) dev_clk = 1'b1;
    end
    obs_pattern = obs;
    if (last_edge == 11) begin
      repeat (HALF / 2) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_ready(input int limit);
    int k = 0;
    while (!tx_ready && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("tx_ready returns", 32'(tx_ready), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset tx_ready", 32'(tx_ready), 32'd1);
    check("reset rx_hold", 32'(rx_hold), 32'd0);
    check("reset oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("reset done/error/ack", {29'd0, done, error, ack_ok}, 32'd0);
    check("reset state", 32'(dbg.state), 32'(ST_IDLE));
    clrn = 1'b1;
    repeat (3) @(negedge clk);

    // Normal send 0xED with ACK: data_oe 0,1,0,0,1,0,0,0,0,0.
    exp_q.push_back({1'b0, 1'b1, 10'h012});
    send(8'hED);
    device(1'b1, 11);
    wait_ready(300);

    // Parity cases: edge-9 data_oe 1 / 0 / 0.
    exp_q.push_back({1'b0, 1'b1, 10'h1FE});
    send(8'h01);
    device(1'b1, 11);
    wait_ready(300);
    exp_q.push_back({1'b0, 1'b1, 10'h0FF});
    send(8'h00);
    device(1'b1, 11);
    wait_ready(300);
    exp_q.push_back({1'b0, 1'b1, 10'h000});
    send(8'hFF);
    device(1'b1, 11);
    wait_ready(300);

    // Device silent: error after FTO cycles, ack_ok keeps the previous 1.
    exp_q.push_back({1'b1, 1'b1, 10'h000});
    send(8'hED);
    wait_ready(FTO + INH + 300);

    // Handshake: 0xF3 offered while busy is dropped; inhibit length measured.
    exp_q.push_back({1'b0, 1'b1, 10'h012});
    send(8'hED);
    tx_data  = 8'hF3;
    tx_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("tx_ready while busy", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    device(1'b1, 11);
    check("clk_oe high cycles", 32'(last_hi), 32'(INH + 1));
    check("inhibit cycles", 32'(last_inh), 32'(INH));
    wait_ready(300);

    // No ACK on 0xF3: data_oe 0,0,1,1,0,0,0,0,0,0 and ack_ok 0.
    exp_q.push_back({1'b0, 1'b0, 10'h00C});
    send(8'hF3);
    device(1'b0, 11);
    wait_ready(300);

    // Reset after edge 4 of 0x00 (data_oe is driving low there).
    send(8'h00);
    device(1'b1, 4);
    check("data_oe before reset", 32'(ps2_data_oe), 32'd1);
    clrn = 1'b0;
    #1;
    check("oe cleared by reset", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("reset mid-frame state", 32'(dbg.state), 32'(ST_IDLE));
    check("reset mid-frame tx_ready", 32'(tx_ready), 32'd1);
    check("reset mid-frame rx_hold", 32'(rx_hold), 32'd0);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    exp_q.push_back({1'b0, 1'b1, 10'h000});
    send(8'hFF);
    device(1'b1, 11);
    wait_ready(300);

    repeat (20) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
